// File: rtl/shifter_right_seq.sv
// Purpose : sequential sign-magnitude right shifter, one magnitude bit per clock.
// Latency : start accepted at edge T -> o_done in cycle T+1+k, k = min(|B|, N-1); k = 0 on error.
// Backpressure: none; in_start is ignored (not queued) while o_busy is high.
//
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   in_start       - request pulse, only sampled in IDLE
//   in_a, in_b     - operand and shift amount, sign-magnitude (bit N-1 = sign)
//   o_out          - registered result, sign-magnitude (0 on error)
//   o_ERR          - registered, last operation had a negative shift amount
//   o_inexact      - registered, a 1-bit was shifted out of the magnitude
//   o_busy         - high whenever the FSM is not IDLE
//   o_done         - one-cycle pulse; result outputs are valid from this cycle
module shifter_right_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] o_out,
  output logic         o_ERR,
  output logic         o_inexact,
  output logic         o_busy,
  output logic         o_done
);

  // Count register only has to hold N-1 (the saturated shift count).
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [N-2:0] MAX_SHIFT = (N-1)'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    state;
  logic          sign_a;
  logic [N-2:0]  mag;
  logic [CW-1:0] cnt;
  logic          sticky;

  logic [N-2:0]  b_mag;
  logic [CW-1:0] cnt_init;
  logic [N-2:0]  mag_next;
  logic          sticky_next;

  // Shift counts of N-1 or more all end with a zero magnitude, so clamp
  // the count; this also bounds the operation latency.
  assign b_mag       = in_b[N-2:0];
  assign cnt_init    = (b_mag >= MAX_SHIFT) ? CW'(N - 1) : CW'(b_mag);
  assign mag_next    = mag >> 1;
  assign sticky_next = sticky | mag[0];

  assign o_busy = (state != ST_IDLE);
  assign o_done = (state == ST_DONE);

  // Result registers are loaded on the edge that enters DONE, so they are
  // already valid in the o_done cycle and hold until the next DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sign_a    <= 1'b0;
      mag       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      o_out     <= '0;
      o_ERR     <= 1'b0;
      o_inexact <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_start) begin
            sign_a <= in_a[N-1];
            mag    <= in_a[N-2:0];
            cnt    <= cnt_init;
            sticky <= 1'b0;
            if (in_b[N-1]) begin
              // Any negative shift amount, including negative zero.
              state     <= ST_DONE;
              o_out     <= '0;
              o_ERR     <= 1'b1;
              o_inexact <= 1'b0;
            end else if (cnt_init == '0) begin
              state     <= ST_DONE;
              o_out     <= in_a;
              o_ERR     <= 1'b0;
              o_inexact <= 1'b0;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          sticky <= sticky_next;
          mag    <= mag_next;
          cnt    <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            // Last shift: publish the post-shift values directly.
            state     <= ST_DONE;
            o_out     <= {sign_a, mag_next};
            o_ERR     <= 1'b0;
            o_inexact <= sticky_next;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_right_seq.sv
// Purpose : self-checking bench for shifter_right_seq (table vectors, corner sequences, random vs model).
// Latency : checks o_done arrives exactly 1+k cycles after the accepting edge.
// Backpressure: checks that starts during busy are ignored and a start right after DONE is accepted.
module tb_shifter_right_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_start = 1'b0;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic [N-1:0] o_out;
  logic         o_ERR;
  logic         o_inexact;
  logic         o_busy;
  logic         o_done;

  int tests = 0;
  int fails = 0;

  shifter_right_seq #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_start (in_start),
    .in_a     (in_a),
    .in_b     (in_b),
    .o_out    (o_out),
    .o_ERR    (o_ERR),
    .o_inexact(o_inexact),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] out;
    logic         err;
    logic         inex;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: divide the magnitude by 2^k; inexact when the remainder is nonzero.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] out, output logic err,
                       output logic inex, output int lat);
    int ma;
    int bm;
    int k;
    int pw;
    logic [N-2:0] rm;
    ma  = int'(a[N-2:0]);
    bm  = int'(b[N-2:0]);
    err = b[N-1];
    k   = err ? 0 : ((bm > N - 1) ? N - 1 : bm);
    pw  = 1 << k;
    rm  = (N-1)'(ma / pw);
    inex = !err && ((ma % pw) != 0);
    out  = err ? '0 : {a[N-1], rm};
    lat  = 1 + k;
  endtask

  // Called just after an edge with the DUT idle.
  task automatic run_op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eout, input logic eerr, input logic einex,
                        input int elat);
    int cyc;
    logic [N-1:0] held;
    in_a = a;
    in_b = b;
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    // Scramble inputs after acceptance; they must have no effect.
    in_a = N'($urandom);
    in_b = N'($urandom);
    cyc = 1;
    while (!o_done && cyc < 40) begin
      chk({nm, " busy"}, 32'(o_busy), 32'd1);
      step();
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(elat));
    chk({nm, " out"}, 32'(o_out), 32'(eout));
    chk({nm, " err"}, 32'(o_ERR), 32'(eerr));
    chk({nm, " inexact"}, 32'(o_inexact), 32'(einex));
    chk({nm, " busy at done"}, 32'(o_busy), 32'd1);
    held = o_out;
    step();
    chk({nm, " done pulse width"}, 32'(o_done), 32'd0);
    chk({nm, " idle after done"}, 32'(o_busy), 32'd0);
    chk({nm, " out held"}, 32'(o_out), 32'(held));
  endtask

  initial begin
    logic [N-1:0] mout;
    logic         merr;
    logic         minex;
    int           mlat;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    int           dones;

    vecs[0] = '{8'h16, 8'h02, 8'h05, 1'b0, 1'b1, 3};
    vecs[1] = '{8'h88, 8'h03, 8'h81, 1'b0, 1'b0, 4};
    vecs[2] = '{8'hC5, 8'h00, 8'hC5, 1'b0, 1'b0, 1};
    vecs[3] = '{8'hC5, 8'h85, 8'h00, 1'b1, 1'b0, 1};
    vecs[4] = '{8'hC5, 8'h80, 8'h00, 1'b1, 1'b0, 1};
    vecs[5] = '{8'h7F, 8'h14, 8'h00, 1'b0, 1'b1, 8};
    vecs[6] = '{8'hFF, 8'h7F, 8'h80, 1'b0, 1'b1, 8};
    vecs[7] = '{8'h40, 8'h06, 8'h01, 1'b0, 1'b0, 7};
    vecs[8] = '{8'h41, 8'h07, 8'h00, 1'b0, 1'b1, 8};
    vecs[9] = '{8'hAA, 8'h01, 8'h95, 1'b0, 1'b0, 2};

    // Reset state.
    repeat (3) step();
    chk("reset out", 32'(o_out), 32'd0);
    chk("reset err", 32'(o_ERR), 32'd0);
    chk("reset inexact", 32'(o_inexact), 32'd0);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset done", 32'(o_done), 32'd0);
    rst = 1'b0;
    step();

    // Table vectors.
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
             vecs[i].out, vecs[i].err, vecs[i].inex, vecs[i].lat);
    end

    // Starts during busy are ignored; a start in the IDLE cycle after DONE is accepted.
    in_a = 8'h16;
    in_b = 8'h02;
    in_start = 1'b1;
    step();
    in_a = 8'h7F;
    in_b = 8'h01;
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      chk("ignore busy", 32'(o_busy), 32'd1);
      if (o_done) begin
        dones++;
        chk("ignore out", 32'(o_out), 32'h05);
      end
      step();
    end
    chk("ignore done count", 32'(dones), 32'd1);
    chk("ignore idle", 32'(o_busy), 32'd0);
    chk("ignore out held", 32'(o_out), 32'h05);
    step();
    in_start = 1'b0;
    chk("back2back busy", 32'(o_busy), 32'd1);
    chk("back2back not done", 32'(o_done), 32'd0);
    step();
    chk("back2back done", 32'(o_done), 32'd1);
    chk("back2back out", 32'(o_out), 32'h3F);
    chk("back2back inexact", 32'(o_inexact), 32'd1);
    step();

    // Reset in the middle of an operation.
    in_a = 8'h7F;
    in_b = 8'h05;
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst out", 32'(o_out), 32'd0);
    chk("midrst err", 32'(o_ERR), 32'd0);
    chk("midrst inexact", 32'(o_inexact), 32'd0);
    chk("midrst busy", 32'(o_busy), 32'd0);
    chk("midrst done", 32'(o_done), 32'd0);
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (o_done) dones++;
    end
    chk("midrst no done", 32'(dones), 32'd0);
    run_op("after rst", 8'h7F, 8'h05, 8'h03, 1'b0, 1'b1, 6);

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if ($urandom_range(0, 3) != 0) rb[N-2:0] = (N-1)'($urandom_range(0, 9));
      model(ra, rb, mout, merr, minex, mlat);
      run_op($sformatf("rand%0d a=%0h b=%0h", i, ra, rb), ra, rb, mout, merr, minex, mlat);
      if ($urandom_range(0, 1) != 0) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
